// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between a processor core and the data memory.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory: accept a RISC-V load/store, access the array for one
// cycle, then hold the response until the processor takes it.
module data_mem_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN  = 64'(DEPTH_WORDS) * 64'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [63:0] rsp_rdata_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] mem_q [DEPTH_WORDS];

    logic [63:0]      offset_d;
    logic [IDX_W-1:0] idx_d;
    logic             err_d;
    logic [63:0]      rd_word_d;
    logic [63:0]      wr_word_d;
    logic [63:0]      load_data_d;

    function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b1;
            2'd1:    return ~off[0];
            2'd2:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    return 8'h01 << off;
            2'd1:    return 8'h03 << off;
            2'd2:    return 8'h0F << off;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] extend_load(input logic [63:0] dw, input logic [2:0] off,
                                                input logic [2:0] f3);
        logic [63:0] sh;
        sh = dw >> {off, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}}, sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    // Unsigned subtraction: addresses below BASE_ADDR wrap high and fall out of range.
    always_comb begin
        logic [7:0]  mask;
        logic [63:0] wsh;
        offset_d    = addr_q - BASE_ADDR;
        idx_d       = offset_d[IDX_W+2:3];
        err_d       = (offset_d >= SPAN)
                    || !is_aligned(addr_q[2:0], funct3_q[1:0])
                    || (we_q ? funct3_q[2] : (funct3_q == 3'b111));
        rd_word_d   = mem_q[idx_d];
        mask        = lane_mask(addr_q[2:0], funct3_q[1:0]);
        wsh         = wdata_q << {addr_q[2:0], 3'b000};
        wr_word_d   = rd_word_d;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) wr_word_d[i*8 +: 8] = wsh[i*8 +: 8];
        end
        load_data_d = extend_load(rd_word_d, addr_q[2:0], funct3_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 64'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q        <= bus.req_we;
                        funct3_q    <= bus.req_funct3;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q && !err_d) mem_q[idx_d] <= wr_word_d;
                    rsp_err_q   <= err_d;
                    rsp_rdata_q <= (we_q || err_d) ? 64'd0 : load_data_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a queue of expected {err, rdata} responses.
module tb_data_mem_responder;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 512;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    data_mem_responder_if bus ();

    data_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [64:0] exp_q [$];
    logic [64:0] cur;
    logic [64:0] dropped;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] er, input logic ee);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        exp_q.push_back({ee, er});
    endtask

    task automatic accept_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wd, input logic [63:0] er, input logic ee);
        logic ok;
        @(negedge clk);
        drive(we, f3, addr, wd, er, ee);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_wait", 64'(ok), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int hold);
        @(negedge clk);
        check({tag, "_lat1_valid"}, 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_lat2_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_queue"}, 64'(exp_q.size() != 0), 64'd1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 65'd0;
        check({tag, "_rdata"}, bus.rsp_rdata, cur[63:0]);
        check({tag, "_err"}, 64'(bus.rsp_err), 64'(cur[64]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
            check({tag, "_hold_rdata"}, bus.rsp_rdata, cur[63:0]);
            check({tag, "_hold_err"}, 64'(bus.rsp_err), 64'(cur[64]));
            check({tag, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 64'd0;
        bus.req_wdata  = 64'd0;
        bus.rsp_ready  = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_err",   64'(bus.rsp_err),   64'd0);
        check("rst_rdata", bus.rsp_rdata,      64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd1);

        // Basic store/load and byte-lane merge
        accept_req(1, 3'b011, BASE + 64'h10, 64'h1122334455667788, 64'd0, 0); collect("sd10", 0);
        accept_req(0, 3'b011, BASE + 64'h10, 64'd0, 64'h1122334455667788, 0); collect("ld10", 0);
        accept_req(1, 3'b000, BASE + 64'h13, 64'hABCD_0000_0000_12F0, 64'd0, 0); collect("sb13", 0);
        accept_req(0, 3'b000, BASE + 64'h13, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 0); collect("lb13", 0);
        accept_req(0, 3'b100, BASE + 64'h13, 64'd0, 64'h0000_0000_0000_00F0, 0); collect("lbu13", 0);
        accept_req(0, 3'b011, BASE + 64'h10, 64'd0, 64'h1122_3344_F066_7788, 0); collect("ld10_b", 0);

        // Error cases leave memory untouched
        accept_req(0, 3'b010, BASE + 64'h12, 64'd0, 64'd0, 1); collect("lw_mis", 0);
        accept_req(1, 3'b001, BASE + 64'h11, 64'hBEEF, 64'd0, 1); collect("sh_mis", 0);
        accept_req(0, 3'b011, 64'h7FFF_FFF8, 64'd0, 64'd0, 1); collect("ld_below", 0);
        accept_req(0, 3'b011, BASE + 64'(DEPTH) * 8, 64'd0, 64'd0, 1); collect("ld_above", 0);
        accept_req(0, 3'b111, BASE + 64'h10, 64'd0, 64'd0, 1); collect("ld_ill", 0);
        accept_req(1, 3'b100, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1); collect("st_ill", 0);
        accept_req(0, 3'b011, BASE + 64'h10, 64'd0, 64'h1122_3344_F066_7788, 0); collect("ld10_c", 0);

        // Word/half widths with sign and zero extension
        accept_req(1, 3'b010, BASE + 64'h14, 64'h8000_0001, 64'd0, 0); collect("sw14", 0);
        accept_req(0, 3'b010, BASE + 64'h14, 64'd0, 64'hFFFF_FFFF_8000_0001, 0); collect("lw14", 0);
        accept_req(0, 3'b110, BASE + 64'h14, 64'd0, 64'h0000_0000_8000_0001, 0); collect("lwu14", 0);
        accept_req(0, 3'b001, BASE + 64'h16, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 0); collect("lh16", 0);
        accept_req(0, 3'b101, BASE + 64'h16, 64'd0, 64'h0000_0000_0000_8000, 0); collect("lhu16", 0);

        // Last in-range doubleword
        accept_req(1, 3'b011, BASE + 64'(DEPTH) * 8 - 8, 64'h5A5A_A5A5_0F0F_F0F0, 64'd0, 0); collect("sd_last", 0);

        // Response held under back-pressure while another request waits
        accept_req(0, 3'b011, BASE + 64'h10, 64'd0, 64'h8000_0001_F066_7788, 0);
        drive(0, 3'b011, BASE + 64'(DEPTH) * 8 - 8, 64'd0, 64'h5A5A_A5A5_0F0F_F0F0, 0);
        collect("hold", 5);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        collect("held_req", 0);

        // Reset during ACCESS cancels the store and the response
        accept_req(1, 3'b011, BASE + 64'h20, 64'h0123_4567_89AB_CDEF, 64'd0, 0); collect("sd20", 0);
        accept_req(1, 3'b011, BASE + 64'h20, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 0);
        dropped = exp_q.pop_back();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstacc_valid", 64'(bus.rsp_valid), 64'd0);
            check("rstacc_ready", 64'(bus.req_ready), 64'd1);
        end
        accept_req(0, 3'b011, BASE + 64'h20, 64'd0, 64'h0123_4567_89AB_CDEF, 0); collect("ld20", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
